// File: rtl/rv_plic_target_core.sv
// rtl/rv_plic_target_core.sv - PLIC gateways, per-target arbitration and claim/complete
module rv_plic_target_core #(
    parameter int NumSrc    = 55,
    parameter int NumTarget = 2,
    parameter int PrioWidth = 3,
    localparam int SrcIdW   = $clog2(NumSrc + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumSrc-1:0]               intr_src_i,
    input  logic [NumSrc-1:0]               le_i,
    input  logic [NumSrc*PrioWidth-1:0]     prio_i,
    input  logic [NumTarget*NumSrc-1:0]     ie_i,
    input  logic [NumTarget*PrioWidth-1:0]  threshold_i,
    input  logic [NumTarget-1:0]            claim_i,
    input  logic [NumTarget-1:0]            complete_i,
    input  logic [NumTarget*SrcIdW-1:0]     complete_id_i,
    output logic [NumSrc-1:0]               ip_o,
    output logic [NumTarget-1:0]            irq_o,
    output logic [NumTarget*SrcIdW-1:0]     irq_id_o
);

    logic [NumSrc-1:0]           src_d, src_q;
    logic [NumSrc-1:0]           ip_d, ip_q;
    logic [NumSrc-1:0]           active_d, active_q;
    logic [NumTarget-1:0]        irq_d, irq_q;
    logic [NumTarget*SrcIdW-1:0] irq_id_d, irq_id_q;

    logic [NumSrc-1:0]           set_w;
    logic [NumSrc-1:0]           claim_hit;
    logic [NumSrc-1:0]           comp_hit;

    // Decode which sources are being claimed or completed by any target this cycle
    always_comb begin
        claim_hit = '0;
        comp_hit  = '0;
        for (int i = 0; i < NumSrc; i++) begin
            for (int t = 0; t < NumTarget; t++) begin
                if (claim_i[t] && (irq_id_q[t*SrcIdW +: SrcIdW] == SrcIdW'(i + 1))) begin
                    claim_hit[i] = 1'b1;
                end
                if (complete_i[t] && (complete_id_i[t*SrcIdW +: SrcIdW] == SrcIdW'(i + 1))) begin
                    comp_hit[i] = 1'b1;
                end
            end
        end
    end

    // Gateways: edge/level detection, pending set/clear and active (claimed) tracking
    always_comb begin
        src_d    = intr_src_i;
        set_w    = '0;
        ip_d     = ip_q;
        active_d = active_q;
        for (int i = 0; i < NumSrc; i++) begin
            set_w[i] = le_i[i] ? (intr_src_i[i] & ~src_q[i]) : intr_src_i[i];
            // A request arriving while the source is in service is dropped
            if (set_w[i] && !active_q[i]) begin
                ip_d[i] = 1'b1;
            end
            if (comp_hit[i]) begin
                active_d[i] = 1'b0;
            end
            // Claim takes priority over both a same-cycle set and a same-cycle complete
            if (claim_hit[i]) begin
                ip_d[i]     = 1'b0;
                active_d[i] = 1'b1;
            end
        end
    end

    // Per-target arbitration: highest priority above threshold, lowest ID on ties
    always_comb begin
        irq_d    = '0;
        irq_id_d = '0;
        for (int t = 0; t < NumTarget; t++) begin
            logic [PrioWidth-1:0] best_prio;
            logic [SrcIdW-1:0]    best_id;
            best_prio = '0;
            best_id   = '0;
            for (int i = 0; i < NumSrc; i++) begin
                // Strict compare keeps the lowest ID; eligibility implies prio >= 1
                if (ip_q[i] && ie_i[t*NumSrc + i] &&
                    (prio_i[i*PrioWidth +: PrioWidth] > threshold_i[t*PrioWidth +: PrioWidth]) &&
                    (prio_i[i*PrioWidth +: PrioWidth] > best_prio)) begin
                    best_prio = prio_i[i*PrioWidth +: PrioWidth];
                    best_id   = SrcIdW'(i + 1);
                end
            end
            irq_d[t]                     = (best_id != '0);
            irq_id_d[t*SrcIdW +: SrcIdW] = best_id;
        end
    end

    // State registers with synchronous reset dropping all pending and claimed state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            ip_q     <= '0;
            active_q <= '0;
            irq_q    <= '0;
            irq_id_q <= '0;
        end else begin
            src_q    <= src_d;
            ip_q     <= ip_d;
            active_q <= active_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign ip_o     = ip_q;
    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

endmodule
